// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width high pulses with a guaranteed low gap.
// Define PULSE_STRETCH_QUEUE_EN to queue events that arrive while a pulse is in progress.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | output low, waiting for an event
// HIGH  | output high, holding for HIGH_CYCLES cycles
// GAP   | output low, holding for GAP_CYCLES cycles before next pulse
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 20,
  parameter int QUEUE_W     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               pulse_in,
  output logic               out_level,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               high_done;
  logic               gap_done;
  logic               ev_busy;

  assign high_done = (state == ST_HIGH) && (cnt == HIGH_LAST);
  assign gap_done  = (state == ST_GAP) && (cnt == GAP_LAST);
  // An event in the final GAP cycle restarts HIGH directly, so it never counts as busy.
  assign ev_busy   = pulse_in && ((state == ST_HIGH) || ((state == ST_GAP) && !gap_done));

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [QUEUE_W-1:0] Q_MAX = '1;
  logic [QUEUE_W-1:0] pend_q;
  logic               dequeue;

  assign dequeue = gap_done && (pend_q != '0);
  assign pending = pend_q;
`else
  assign pending = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      state     <= ST_IDLE;
      out_level <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      overflow  <= 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
      pend_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pulse_in) begin
            state     <= ST_HIGH;
            out_level <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (high_done) begin
            state     <= ST_GAP;
            out_level <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            cnt <= '0;
`ifdef PULSE_STRETCH_QUEUE_EN
            if (pulse_in || dequeue) begin
`else
            if (pulse_in) begin
`endif
              state     <= ST_HIGH;
              out_level <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_level <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase

`ifdef PULSE_STRETCH_QUEUE_EN
      // A dequeue with a simultaneous event leaves the count unchanged.
      if (dequeue) begin
        if (!pulse_in) pend_q <= pend_q - 1'b1;
      end else if (ev_busy) begin
        if (pend_q == Q_MAX) overflow <= 1'b1;
        else                 pend_q   <= pend_q + 1'b1;
      end
`else
      if (ev_busy) overflow <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (HIGH=4, GAP=4, QUEUE_W=2); follows PULSE_STRETCH_QUEUE_EN.
module tb_pulse_stretcher;
  localparam int QW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr;
  logic          pulse_in;
  logic          out_level;
  logic          busy;
  logic [QW-1:0] pending;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Trace index k holds outputs seen after the edge that sampled input cycle k-1.
  logic [63:0]   out_tr;
  logic [63:0]   busy_tr;
  logic [63:0]   ovf_tr;
  logic [QW-1:0] pend_tr [64];

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HIGH_CYCLES(4),
    .GAP_CYCLES (4),
    .CNT_W      (20),
    .QUEUE_W    (QW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .pulse_in (pulse_in),
    .out_level(out_level),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [QW-1:0] pend_or(input int lo, input int hi);
    logic [QW-1:0] acc;
    acc = '0;
    for (int i = lo; i <= hi; i++) acc = acc | pend_tr[i];
    return acc;
  endfunction

  task automatic run_scn(input logic [63:0] pin_mask, input logic [63:0] clr_mask, input int ncyc);
    pulse_in = 1'b0;
    clr      = 1'b1;
    @(posedge clk); #1;
    clr     = 1'b0;
    out_tr  = '0;
    busy_tr = '0;
    ovf_tr  = '0;
    for (int i = 0; i < 64; i++) pend_tr[i] = '0;
    out_tr[0]  = out_level;
    busy_tr[0] = busy;
    ovf_tr[0]  = overflow;
    pend_tr[0] = pending;
    for (int c = 0; c < ncyc; c++) begin
      pulse_in = pin_mask[c];
      clr      = clr_mask[c];
      @(posedge clk); #1;
      out_tr[c+1]  = out_level;
      busy_tr[c+1] = busy;
      ovf_tr[c+1]  = overflow;
      pend_tr[c+1] = pending;
    end
    pulse_in = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    clr      = 1'b0;
    pulse_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rst_hold", 64'({out_level, busy, overflow, pending}), 64'd0);
    end
    pulse_in = 1'b0;
    reset_n  = 1'b1;

    // Single event at cycle 10.
    run_scn(rng(10, 10), 64'd0, 30);
    check("single_out",  out_tr,  rng(11, 14));
    check("single_busy", busy_tr, rng(11, 18));
    check("single_ovf",  ovf_tr,  64'd0);
    check("single_pend", 64'(pend_or(0, 30)), 64'd0);

    // Event in the final GAP cycle starts a new pulse straight away.
    run_scn(rng(10, 10) | rng(18, 18), 64'd0, 34);
    check("lastgap_out",  out_tr,  rng(11, 14) | rng(19, 22));
    check("lastgap_busy", busy_tr, rng(11, 26));
    check("lastgap_ovf",  ovf_tr,  64'd0);
    check("lastgap_pend", 64'(pend_or(0, 34)), 64'd0);

    // Events at 10, 12 and 18 (18 coincides with a GAP end).
    run_scn(rng(10, 10) | rng(12, 12) | rng(18, 18), 64'd0, 40);
`ifdef PULSE_STRETCH_QUEUE_EN
    check("mix_out",    out_tr,  rng(11, 14) | rng(19, 22) | rng(27, 30));
    check("mix_busy",   busy_tr, rng(11, 34));
    check("mix_ovf",    ovf_tr,  64'd0);
    check("mix_pend13", 64'(pend_tr[13]), 64'd1);
    check("mix_pend19", 64'(pend_tr[19]), 64'd1);
    check("mix_pend27", 64'(pend_tr[27]), 64'd0);
`else
    check("mix_out",  out_tr,  rng(11, 14) | rng(19, 22));
    check("mix_busy", busy_tr, rng(11, 26));
    check("mix_ovf",  ovf_tr,  rng(13, 40));
    check("mix_pend", 64'(pend_or(0, 40)), 64'd0);
`endif

    // clr during HIGH with two extra events already seen.
    run_scn(rng(10, 12), rng(13, 13), 40);
    check("clr_out",  out_tr,  rng(11, 13));
    check("clr_busy", busy_tr, rng(11, 13));
`ifdef PULSE_STRETCH_QUEUE_EN
    check("clr_pend13", 64'(pend_tr[13]), 64'd2);
    check("clr_ovf",    ovf_tr, 64'd0);
`else
    check("clr_ovf",    ovf_tr, rng(12, 13));
`endif
    check("clr_pend_after", 64'(pend_or(14, 40)), 64'd0);

`ifdef PULSE_STRETCH_QUEUE_EN
    // Three queued events at 10, 12 and 13.
    run_scn(rng(10, 10) | rng(12, 13), 64'd0, 40);
    check("three_out",    out_tr,  rng(11, 14) | rng(19, 22) | rng(27, 30));
    check("three_busy",   busy_tr, rng(11, 34));
    check("three_ovf",    ovf_tr,  64'd0);
    check("three_pend14", 64'(pend_tr[14]), 64'd2);
    check("three_pend19", 64'(pend_tr[19]), 64'd1);
    check("three_pend27", 64'(pend_tr[27]), 64'd0);

    // Five events while busy overfill the 3-deep queue; clr at 52 clears overflow.
    run_scn(rng(10, 15), rng(52, 52), 55);
    check("sat_out",    out_tr,  rng(11, 14) | rng(19, 22) | rng(27, 30) | rng(35, 38));
    check("sat_busy",   busy_tr, rng(11, 42));
    check("sat_ovf",    ovf_tr,  rng(15, 52));
    check("sat_pend14", 64'(pend_tr[14]), 64'd3);
    check("sat_pend16", 64'(pend_tr[16]), 64'd3);
    check("sat_pend19", 64'(pend_tr[19]), 64'd2);
    check("sat_pend35", 64'(pend_tr[35]), 64'd0);
`else
    // Events during HIGH and GAP are dropped; overflow holds until clr at 40.
    run_scn(rng(10, 10) | rng(13, 13) | rng(16, 16), rng(40, 40), 44);
    check("drop_out",  out_tr,  rng(11, 14));
    check("drop_busy", busy_tr, rng(11, 18));
    check("drop_ovf",  ovf_tr,  rng(14, 40));
    check("drop_pend", 64'(pend_or(0, 44)), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
